// File: rtl/adder_seq_pkg.sv
// Shared definitions for the byte-serial adder sequencer and its arbiter.
// Provides the FSM state encodings, the slice width, the requester count and the overflow helper.
package adder_seq_pkg;

    localparam int BYTE_W = 8;
    localparam int NREQ   = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Two's-complement overflow: carry into the MSB differs from carry out of it.
    function automatic logic sgn_ovf(input logic c_into_msb, input logic c_out_msb);
        return c_into_msb ^ c_out_msb;
    endfunction

endpackage

// File: rtl/adder_share_seq_arb.sv
// Two-way round-robin arbiter. The pointer moves to the loser whenever a grant is issued.
// en_i restricts arbitration to the window in which the sequencer can accept work.
module rr_arb2
    import adder_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic            gnt_idx_o
);

    logic ptr_q;
    logic ptr_d;
    logic idx;
    logic fire;

    always_comb begin
        idx = 1'b0;
        if (req_i[0] && req_i[1]) begin
            idx = ptr_q;
        end else if (req_i[1]) begin
            idx = 1'b1;
        end
        fire       = en_i && (|req_i);
        gnt_o      = '0;
        gnt_o[idx] = fire;
        gnt_idx_o  = idx;
        // Grant is always taken because ready is the grant itself.
        ptr_d      = fire ? ~idx : ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/adder_share_seq.sv
// Time-shares one combinational 8-bit adder between two requesters for NBYTES-wide adds.
// Slices are fed LSB first, one per cycle, with the carry chained through a register.
module adder_share_seq
    import adder_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*BYTE_W*NBYTES-1:0] req_a,
    input  logic [NREQ*BYTE_W*NBYTES-1:0] req_b,
    input  logic [NREQ-1:0]            req_cin,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_id,
    output logic [BYTE_W*NBYTES-1:0]   rsp_sum,
    output logic                       rsp_cout,
    output logic                       rsp_ovf,
    output logic [BYTE_W-1:0]          add_a,
    output logic [BYTE_W-1:0]          add_b,
    output logic                       add_cin,
    input  logic [BYTE_W-1:0]          add_sum,
    input  logic                       add_cout,
    input  logic                       add_c6,
    output logic                       busy
);

    localparam int W  = BYTE_W * NBYTES;
    localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

    logic [1:0]      state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [KW-1:0]   k_q, k_d;
    logic            carry_q, carry_d;
    logic            id_q, id_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic [NREQ-1:0] gnt;
    logic            gnt_idx;
    logic            arb_en;
    logic            accept;

    // Holding off arbitration during reset keeps req_ready low while rst is high.
    assign arb_en = (state_q == ST_IDLE) && !rst;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_valid),
        .en_i      (arb_en),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    assign req_ready = gnt;
    assign accept    = |(req_valid & gnt);
    assign rsp_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
    assign rsp_ovf   = ovf_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        k_d     = k_q;
        carry_d = carry_q;
        id_d    = id_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d     = gnt_idx ? req_a[W +: W] : req_a[0 +: W];
                    b_d     = gnt_idx ? req_b[W +: W] : req_b[0 +: W];
                    carry_d = req_cin[gnt_idx];
                    id_d    = gnt_idx;
                    k_d     = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                add_a   = a_q[int'(k_q)*BYTE_W +: BYTE_W];
                add_b   = b_q[int'(k_q)*BYTE_W +: BYTE_W];
                add_cin = carry_q;
                sum_d[int'(k_q)*BYTE_W +: BYTE_W] = add_sum;
                carry_d = add_cout;
                k_d     = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    cout_d  = add_cout;
                    ovf_d   = sgn_ovf(add_c6, add_cout);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            id_q    <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            id_q    <= id_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_adder_share_seq.sv
// Directed bench for adder_share_seq with a behavioural 8-bit adder closing the loop.
module tb_adder_share_seq;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     req_valid, req_ready, req_cin;
    logic [2*W-1:0] req_a, req_b;
    logic           rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_ovf;
    logic [W-1:0]   rsp_sum;
    logic [7:0]     add_a, add_b, add_sum;
    logic           add_cin, add_cout, add_c6, busy;
    logic [8:0]     full9;
    logic [7:0]     low8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        full9 = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
        low8  = {1'b0, add_a[6:0]} + {1'b0, add_b[6:0]} + {7'd0, add_cin};
    end
    assign add_sum  = full9[7:0];
    assign add_cout = full9[8];
    assign add_c6   = low8[7];

    adder_share_seq #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .add_c6    (add_c6),
        .busy      (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic cin);
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_cin[id]      = cin;
        req_valid[id]    = 1'b1;
    endtask

    task automatic wait_ready(input int id, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (req_ready[id] === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (rsp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic do_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, output bit ok);
        bit rdy;
        drive_req(id, a, b, cin);
        wait_ready(id, rdy);
        if (!rdy) begin
            req_valid[id] = 1'b0;
            ok = 1'b0;
            return;
        end
        step();
        req_valid[id] = 1'b0;
        wait_rsp(ok);
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_cin = '0;
        step(); step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
        checks++; if (rsp_sum !== '0) begin errors++; $display("FAIL reset_rsp_sum: got %h want 0", rsp_sum); end
        checks++; if ({rsp_id, rsp_cout, rsp_ovf} !== 3'b000) begin errors++; $display("FAIL reset_rsp_flags: got %b want 000", {rsp_id, rsp_cout, rsp_ovf}); end
        checks++; if ({add_a, add_b, add_cin} !== 17'd0) begin errors++; $display("FAIL reset_adder_drive: got %h want 0", {add_a, add_b, add_cin}); end
        rst = 1'b0;
        step();
        checks++; if (req_ready !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL idle_no_valid: ready=%b busy=%0b want 00/0", req_ready, busy); end
    endtask

    task automatic test_single();
        bit          ok;
        bit          early;
        logic [31:0] trace;
        rsp_ready = 1'b1;
        early = 1'b0;
        trace = '0;
        drive_req(0, 32'h0000_00FF, 32'h0000_0001, 1'b0);
        wait_ready(0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_grant: got no ready want ready[0]"); end
        step();
        req_valid[0] = 1'b0;
        for (int i = 0; i < NB; i++) begin
            trace[8*i +: 8] = add_a;
            if (rsp_valid === 1'b1) early = 1'b1;
            step();
        end
        checks++; if (early || rsp_valid !== 1'b1) begin errors++; $display("FAIL single_latency: early=%0b valid=%0b want 0/1", early, rsp_valid); end
        checks++; if (trace !== 32'h0000_00FF) begin errors++; $display("FAIL single_add_a_seq: got %h want 000000ff", trace); end
        checks++; if (rsp_sum !== 32'h0000_0100) begin errors++; $display("FAIL single_sum: got %h want 00000100", rsp_sum); end
        checks++; if ({rsp_cout, rsp_ovf, rsp_id} !== 3'b000) begin errors++; $display("FAIL single_flags: got %b want 000", {rsp_cout, rsp_ovf, rsp_id}); end
        step();
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_release: valid=%0b busy=%0b want 0/0", rsp_valid, busy); end
    endtask

    task automatic test_ripple();
        bit ok;
        rsp_ready = 1'b1;
        do_op(1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ripple_timeout: got no response want response"); end
        checks++; if (rsp_sum !== 32'h0) begin errors++; $display("FAIL ripple_sum: got %h want 00000000", rsp_sum); end
        checks++; if ({rsp_cout, rsp_ovf, rsp_id} !== 3'b101) begin errors++; $display("FAIL ripple_flags: got %b want 101", {rsp_cout, rsp_ovf, rsp_id}); end
        step();
    endtask

    task automatic test_overflow();
        bit ok;
        rsp_ready = 1'b1;
        do_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout: got no response want response"); end
        checks++; if (rsp_sum !== 32'h8000_0000) begin errors++; $display("FAIL ovf_sum: got %h want 80000000", rsp_sum); end
        checks++; if ({rsp_cout, rsp_ovf} !== 2'b01) begin errors++; $display("FAIL ovf_flags: got %b want 01", {rsp_cout, rsp_ovf}); end
        step();
    endtask

    task automatic test_contention();
        bit          ok;
        logic [31:0] exp_sum;
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        step();
        req_a[0 +: W] = 32'h1111_1111; req_b[0 +: W] = 32'h2222_2222; req_cin[0] = 1'b0;
        req_a[W +: W] = 32'h8000_0000; req_b[W +: W] = 32'h8000_0000; req_cin[1] = 1'b1;
        req_valid = 2'b11;
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL cont_first_grant: got %b want 01", req_ready); end
        for (int n = 0; n < 4; n++) begin
            exp_sum = (n % 2 == 0) ? 32'h3333_3333 : 32'h0000_0001;
            wait_rsp(ok);
            checks++; if (!ok) begin errors++; $display("FAIL cont_timeout_%0d: got no response want response", n); end
            checks++; if (rsp_id !== n[0]) begin errors++; $display("FAIL cont_id_%0d: got %0b want %0b", n, rsp_id, n[0]); end
            checks++; if (rsp_sum !== exp_sum) begin errors++; $display("FAIL cont_sum_%0d: got %h want %h", n, rsp_sum, exp_sum); end
            checks++; if ({rsp_cout, rsp_ovf} !== ((n % 2 == 0) ? 2'b00 : 2'b11)) begin errors++; $display("FAIL cont_flags_%0d: got %b", n, {rsp_cout, rsp_ovf}); end
            if (n == 0) begin
                for (int s = 0; s < 3; s++) begin
                    step();
                    checks++;
                    if (rsp_valid !== 1'b1 || rsp_sum !== 32'h3333_3333 || rsp_id !== 1'b0 || req_ready !== 2'b00) begin
                        errors++;
                        $display("FAIL cont_stall_%0d: valid=%0b sum=%h id=%0b ready=%b want 1/33333333/0/00", s, rsp_valid, rsp_sum, rsp_id, req_ready);
                    end
                end
            end
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int cnt;
        rsp_ready = 1'b1;
        drive_req(0, 32'h0000_0001, 32'h0000_0002, 1'b0);
        wait_rsp(ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: got no response want response"); end
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (rsp_valid !== 1'b1 && cnt < 20);
        checks++; if (cnt !== NB + 2) begin errors++; $display("FAIL b2b_period: got %0d want %0d", cnt, NB + 2); end
        checks++; if (rsp_sum !== 32'h0000_0003) begin errors++; $display("FAIL b2b_sum: got %h want 00000003", rsp_sum); end
        req_valid = '0;
        step();
    endtask

    task automatic test_reset_mid();
        bit ok;
        rsp_ready = 1'b1;
        drive_req(0, 32'h0102_0304, 32'h1020_3040, 1'b0);
        wait_ready(0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_grant: got no ready want ready[0]"); end
        step();
        step();
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || add_a !== 8'h00 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL mid_abort: busy=%0b valid=%0b add_a=%h ready=%b want 0/0/00/00", busy, rsp_valid, add_a, req_ready);
        end
        step();
        rst = 1'b0;
        wait_rsp(ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_timeout: got no response want response"); end
        checks++; if (rsp_sum !== 32'h1122_3344 || rsp_id !== 1'b0) begin errors++; $display("FAIL mid_result: sum=%h id=%0b want 11223344/0", rsp_sum, rsp_id); end
        req_valid = '0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_ripple();
        test_overflow();
        test_contention();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_share_seq.md
Name: adder_share_seq

Overview:
- Sequencer/arbiter that time-shares the single 8-bit ripple `full_adder` datapath between two requesters.
- Each request is a wide add of NBYTES bytes. The block arbitrates round-robin, then feeds one byte slice per cycle to the adder, LSB first.
- Carry is chained between slices through a register. The assembled sum is returned on a tagged response channel.
- Sits between the client logic and the `full_adder` instance. The adder stays purely combinational.

Parameters:
- NBYTES, 4, operand width in bytes; must be ≥1; W = 8*NBYTES (local, derived).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  2  request valid per requester
- req_ready  out  2  request accepted (one-hot or zero)
- req_a  in  2*W  operand A; requester i uses bits [i*W +: W]
- req_b  in  2*W  operand B, same packing as req_a
- req_cin  in  2  carry-in per requester
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumed
- rsp_id  out  1  index of the requester owning the result
- rsp_sum  out  W  sum
- rsp_cout  out  1  carry out of MSB
- rsp_ovf  out  1  signed overflow (carry into MSB XOR carry out of MSB)
- add_a  out  8  byte slice of A driven to the adder A
- add_b  out  8  byte slice of B driven to the adder B
- add_cin  out  1  driven to the adder Cin
- add_sum  in  8  from the adder Sum
- add_cout  in  1  from the adder Cout
- add_c6  in  1  from the adder Cin_out[6] (carry into bit 7)
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE; req_ready=0; rsp_valid=0; rsp_id=0; rsp_sum=0; rsp_cout=0; rsp_ovf=0; add_a=0; add_b=0; add_cin=0; busy=0; round-robin pointer=0 (requester 0 has priority first).
- Reset mid-operation aborts the operation. No response is produced and the captured operands are discarded.
- State IDLE:
  - If any req_valid is set, grant one requester. When both are valid, grant the one at the pointer, then flip the pointer to the other requester.
  - When only one is valid, grant it; the pointer is set to the other requester.
  - req_ready is combinational in IDLE: req_ready[g]=1 for the granted index g, 0 otherwise. Handshake = req_valid & req_ready.
  - On handshake: latch A, B and cin of g into internal registers, latch id=g, set byte index k=0, carry register=cin, go to RUN.
- State RUN:
  - Drive add_a=A[8k+:8], add_b=B[8k+:8], add_cin=carry register (combinational from registers).
  - Each cycle: store add_sum into sum byte k, carry register←add_cout, k←k+1.
  - On k=NBYTES-1: also capture rsp_cout=add_cout and rsp_ovf=add_c6^add_cout, then go to DONE.
  - req_ready=0 throughout RUN and DONE.
- State DONE:
  - rsp_valid=1; rsp_sum, rsp_cout, rsp_ovf and rsp_id stay stable until handshake.
  - On rsp_valid&rsp_ready: rsp_valid←0, go to IDLE.
  - Back-to-back operation is allowed: the next request can be accepted in the cycle after DONE exits.
- Outside RUN, add_a, add_b and add_cin are held at 0.
- Latency: request handshake at cycle T gives rsp_valid at T+NBYTES+1. Throughput is one operation per NBYTES+2 cycles when rsp_ready is held high.
- Arithmetic: unsigned modulo 2^W sum plus carry out; rsp_ovf is the two's-complement overflow of the full W-bit add.
- NBYTES=1: RUN lasts one cycle.
- A req_valid deasserted before handshake is ignored with no side effects. A requester that stays valid without being granted keeps its request pending and gets the next grant.

Decomposition:
- Shared package `adder_seq_pkg`: state enum (IDLE, RUN, DONE), byte-width constant 8, requester count 2.
- One natural sub-module: `rr_arb2` (2-way round-robin arbiter with grant and pointer update on accept).
- The byte-slice mux and the sum assembly stay inline.

Test Plan:
- Reset then idle: rst pulse → all outputs 0, busy=0, req_ready=0 with no valid.
- Single add, NBYTES=4, req 0: A=0x0000_00FF, B=0x0000_0001, cin=0 → after 5 cycles rsp_sum=0x0000_0100, rsp_cout=0, rsp_ovf=0, rsp_id=0; add_a sequence FF,00,00,00.
- Full carry ripple, req 1: A=0xFFFF_FFFF, B=0x0000_0000, cin=1 → rsp_sum=0, rsp_cout=1, rsp_ovf=0, rsp_id=1.
- Signed overflow: A=0x7FFF_FFFF, B=0x0000_0001, cin=0 → rsp_sum=0x8000_0000, rsp_cout=0, rsp_ovf=1.
- Contention: both valid from reset → grant 0 first, then 1. Both held valid for 4 operations → grants alternate 0,1,0,1. rsp_ready low for 3 cycles in DONE → outputs held stable and no new req_ready.
- Async reset asserted at cycle 2 of RUN → rsp_valid stays 0, busy=0 immediately. The pending request is re-accepted after reset release and completes correctly.
